// File: rtl/sc_pkg.sv
// Shared types and LFSR tap table for the stochastic-number generators.
// Tap masks are maximal-length polynomials, bit i set means state[i] feeds back.
// No logic here; widths outside SC_MIN_WIDTH..SC_MAX_WIDTH get an all-zero mask.
package sc_pkg;

  localparam int SC_MIN_WIDTH = 4;
  localparam int SC_MAX_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sng_state_t;

  function automatic logic [SC_MAX_WIDTH-1:0] lfsr_taps(input int width);
    logic [SC_MAX_WIDTH-1:0] taps;
    taps = '0;
    case (width)
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = '0;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR shifting toward the MSB; SNG_ZERO_STATE_EN adds the all-zero state (de Bruijn).
// Latency: new value one cycle after step; load forces SEED and wins over step.
// Backpressure: state holds whenever step is low.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic fb;

  // Every tap mask includes the MSB, so the extra term splits 100..0 -> 000..0 -> 000..1.
  always_comb begin
`ifdef SNG_ZERO_STATE_EN
    fb = (^(state & TAPS)) ^ (state[WIDTH-2:0] == '0);
`else
    fb = ^(state & TAPS);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/sng_corr_pair.sv
// Correlated SNG pair: one shared LFSR value compared against latched dividend/divisor (SNG_ZERO_STATE_EN selects 2^W-beat streams).
// Latency: pair accepted in cycle T, first bit pair valid in T+1; one idle bubble between streams.
// Backpressure: out_ready low freezes LFSR, beat counter and outputs; in_ready is low for the whole stream.
module sng_corr_pair
  import sc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dividend,
  output logic             divisor,
  output logic             last,
  output logic             busy
);

  // Counter value while the final beat is presented.
`ifdef SNG_ZERO_STATE_EN
  localparam logic [WIDTH:0] LAST_IDX = (WIDTH+1)'((1 << WIDTH) - 1);
`else
  localparam logic [WIDTH:0] LAST_IDX = (WIDTH+1)'((1 << WIDTH) - 2);
`endif

  sng_state_t       state_q;
  sng_state_t       state_d;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] r;
  logic [WIDTH:0]   cnt;
  logic             accept;
  logic             xfer;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    last      = 1'b0;
    dividend  = 1'b0;
    divisor   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        dividend  = (op_a > r);
        divisor   = (op_b > r);
        last      = (cnt == LAST_IDX);
        if (out_ready && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      cnt  <= '0;
    end else if (accept) begin
      op_a <= in_a;
      op_b <= in_b;
      cnt  <= '0;
    end else if (xfer) begin
      cnt <= cnt + 1'b1;
    end
  end

  sc_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (xfer),
    .state (r)
  );

endmodule

// File: tb/tb_sng_corr_pair.sv
// Directed bench for sng_corr_pair at WIDTH=4, SEED=1; expectations adapt to SNG_ZERO_STATE_EN.
// Reference LFSR order for taps 0xC from seed 1 is tabulated by hand below.
module tb_sng_corr_pair;

  localparam int W = 4;
`ifdef SNG_ZERO_STATE_EN
  localparam int N  = 16;
  localparam int ZS = 1;
`else
  localparam int N  = 15;
  localparam int ZS = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         dividend;
  logic         divisor;
  logic         last;
  logic         busy;

  always #5 clk = ~clk;

  sng_corr_pair #(.WIDTH(W), .SEED(4'd1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .last      (last),
    .busy      (busy)
  );

  // LFSR values per beat; the trailing 0 only appears with the zero-state extension.
  logic [3:0] r_tab [16] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                             4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd0};

  int          errors = 0;
  int          checks = 0;
  logic [15:0] got_d, got_v, got_l;
  int          got_n;
  bit          tmo;
  int          inrdy_bad;
  int          stall_cnt;
  logic [6:0]  stall_obs [4];
  logic        first_vld;

  function automatic logic [15:0] exp_stream(input logic [3:0] op);
    logic [15:0] e;
    e = '0;
    for (int k = 0; k < N; k++) e[k] = (op > r_tab[k]);
    return e;
  endfunction

  task automatic start_pair(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    first_vld = out_valid;
  endtask

  // Consumes one stream; returns at the negedge presenting the last (or abort) beat.
  task automatic collect(input int stall_beat, input int stall_len, input int abort_beat);
    int cyc;
    bit done;
    cyc = 0; done = 0; got_n = 0; tmo = 0; stall_cnt = 0; inrdy_bad = 0;
    got_d = '0; got_v = '0; got_l = '0;
    while (!done) begin
      if (busy && in_ready) inrdy_bad++;
      if (out_valid) begin
        if (got_n + 1 == abort_beat) begin
          done = 1;
        end else if (got_n + 1 == stall_beat && stall_cnt < stall_len) begin
          out_ready = 1'b0;
          stall_obs[stall_cnt] = {dividend, divisor, last, dut.u_lfsr.state};
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
          got_d[got_n] = dividend;
          got_v[got_n] = divisor;
          got_l[got_n] = last;
          got_n++;
          if (last || got_n >= 16) done = 1;
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
        if (cyc > 100) begin
          tmo = 1;
          done = 1;
        end
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, dividend, divisor, last, busy} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 100000", {in_ready, out_valid, dividend, divisor, last, busy});
    end
    checks++;
    if (dut.u_lfsr.state !== 4'd1 || dut.cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset_lfsr_cnt: got lfsr=%0d cnt=%0d want 1 0", dut.u_lfsr.state, dut.cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream_5_12();
    start_pair(4'd5, 4'd12);
    in_valid = 1'b0;
    checks++;
    if (first_vld !== 1'b1) begin
      errors++;
      $display("FAIL first_beat_latency: got out_valid=%b want 1", first_vld);
    end
    collect(0, 0, 0);
    checks++;
    if (tmo || got_n != N) begin
      errors++;
      $display("FAIL beats_5_12: got %0d (timeout=%0d) want %0d", got_n, tmo, N);
    end
    checks++;
    if (got_d !== exp_stream(4'd5) || got_v !== exp_stream(4'd12)) begin
      errors++;
      $display("FAIL bits_5_12: got %h/%h want %h/%h", got_d, got_v, exp_stream(4'd5), exp_stream(4'd12));
    end
    checks++;
    if ($countones(got_d) != 5 - (1 - ZS) || $countones(got_v) != 12 - (1 - ZS)) begin
      errors++;
      $display("FAIL ones_5_12: got %0d/%0d want %0d/%0d", $countones(got_d), $countones(got_v), 5 - (1 - ZS), 12 - (1 - ZS));
    end
    checks++;
    if ((got_d & ~got_v) !== 16'h0) begin
      errors++;
      $display("FAIL correlation: got violations %h want 0", got_d & ~got_v);
    end
    checks++;
    if (got_l !== 16'(1 << (N - 1))) begin
      errors++;
      $display("FAIL last_position: got %h want %h", got_l, 16'(1 << (N - 1)));
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL bubble_after_last: got vld/busy/rdy=%b want 001", {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_extremes();
    start_pair(4'd0, 4'd15);
    in_valid = 1'b0;
    collect(0, 0, 0);
    checks++;
    if (got_d !== 16'h0 || $countones(got_v) != 15 - (1 - ZS) || got_v !== exp_stream(4'd15)) begin
      errors++;
      $display("FAIL zero_a: got %h/%h want 0/%h", got_d, got_v, exp_stream(4'd15));
    end
    @(negedge clk);
    start_pair(4'd15, 4'd15);
    in_valid = 1'b0;
    collect(0, 0, 0);
    checks++;
    if (got_d !== exp_stream(4'd15) || got_v !== exp_stream(4'd15) || $countones(got_d) != 15 - (1 - ZS)) begin
      errors++;
      $display("FAIL full_scale: got %h/%h want %h", got_d, got_v, exp_stream(4'd15));
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [15:0] ed, ev;
    ed = exp_stream(4'd5);
    ev = exp_stream(4'd12);
    start_pair(4'd5, 4'd12);
    in_valid = 1'b0;
    collect(3, 3, 0);
    checks++;
    if (tmo || got_n != N || stall_cnt != 3) begin
      errors++;
      $display("FAIL stall_beats: got %0d stalls=%0d want %0d stalls=3", got_n, stall_cnt, N);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall_obs[i] !== {ed[2], ev[2], 1'b0, r_tab[2]}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %b want %b", i, stall_obs[i], {ed[2], ev[2], 1'b0, r_tab[2]});
      end
    end
    checks++;
    if (got_d !== ed || got_v !== ev || got_l !== 16'(1 << (N - 1))) begin
      errors++;
      $display("FAIL stall_sequence: got %h/%h/%h want %h/%h/%h", got_d, got_v, got_l, ed, ev, 16'(1 << (N - 1)));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    start_pair(4'd5, 4'd12);
    in_a = 4'd3;
    in_b = 4'd9;
    collect(0, 0, 0);
    checks++;
    if (inrdy_bad != 0 || got_d !== exp_stream(4'd5) || got_v !== exp_stream(4'd12)) begin
      errors++;
      $display("FAIL b2b_first: got rdy_viol=%0d bits %h/%h want 0 %h/%h", inrdy_bad, got_d, got_v, exp_stream(4'd5), exp_stream(4'd12));
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_bubble: got vld/rdy=%b want 01", {out_valid, in_ready});
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || dut.u_lfsr.state !== 4'd1) begin
      errors++;
      $display("FAIL b2b_restart: got vld=%b lfsr=%0d want 1 1", out_valid, dut.u_lfsr.state);
    end
    collect(0, 0, 0);
    checks++;
    if (got_n != N || got_d !== exp_stream(4'd3) || got_v !== exp_stream(4'd9) || $countones(got_d) != 3 - (1 - ZS)) begin
      errors++;
      $display("FAIL b2b_second: got n=%0d %h/%h want %0d %h/%h", got_n, got_d, got_v, N, exp_stream(4'd3), exp_stream(4'd9));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    start_pair(4'd9, 4'd14);
    in_valid = 1'b0;
    collect(0, 0, 7);
    checks++;
    if (got_n != 6 || divisor !== 1'b1 || dividend !== 1'b0) begin
      errors++;
      $display("FAIL pre_abort: got n=%0d d/v=%b%b want 6 01", got_n, dividend, divisor);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, dividend, divisor, last, busy} !== 6'b100000 || dut.u_lfsr.state !== 4'd1 || dut.cnt !== 5'd0) begin
      errors++;
      $display("FAIL async_abort: got %b lfsr=%0d cnt=%0d want 100000 1 0", {in_ready, out_valid, dividend, divisor, last, busy}, dut.u_lfsr.state, dut.cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_pair(4'd9, 4'd14);
    in_valid = 1'b0;
    collect(0, 0, 0);
    checks++;
    if (tmo || got_n != N || got_d !== exp_stream(4'd9) || got_v !== exp_stream(4'd14) || got_l !== 16'(1 << (N - 1))) begin
      errors++;
      $display("FAIL post_reset_stream: got n=%0d %h/%h want %0d %h/%h", got_n, got_d, got_v, N, exp_stream(4'd9), exp_stream(4'd14));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream_5_12();
    test_extremes();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
